renode_ahb_subordinate_bridge: RTL and testbench

AHB-Lite subordinate front-end; the responder end of the AHB link whose initiator drives single NONSEQ transfers.
- Accepts address/data phases, inserts wait states and converts each valid transfer into a held request on a simple backend req/resp interface, served by the Renode runtime or a local model.
- Returns OKAY/ERROR per AHB rules, including the two-cycle ERROR response.
- A watchdog turns a stalled backend into an ERROR response.

---
 rtl/renode_ahb_pkg.sv | 37 +++
 rtl/renode_ahb_timeout_counter.sv | 32 +++
 rtl/renode_ahb_subordinate_bridge.sv | 157 +++++++++++++++
 tb/tb_renode_ahb_subordinate_bridge.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/renode_ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the Renode bus bridges.
package renode_ahb_pkg;

    typedef enum logic [1:0] {
        TransferIdle          = 2'b00,
        TransferBusy          = 2'b01,
        TransferNonSequential = 2'b10,
        TransferSequential    = 2'b11
    } transfer_e;

    typedef enum logic {
        RespOkay  = 1'b0,
        RespError = 1'b1
    } response_t;

    typedef enum logic [2:0] {
        Idle,
        WriteData,
        Request,
        Response,
        Error1,
        Error2
    } subordinate_state_e;

    // Legal when the beat fits the data bus and the address is aligned to the beat size.
    function automatic logic is_transfer_legal(input logic [2:0] addr,
                                               input logic [2:0] size,
                                               input int unsigned data_width);
        logic [2:0] mask;
        if (32'(size) > $clog2(data_width / 8)) begin
            return 1'b0;
        end
        mask = 3'((8'd1 << size) - 8'd1);
        return (addr & mask) == 3'd0;
    endfunction

endpackage

// File: rtl/renode_ahb_timeout_counter.sv
// Watchdog for the backend request phase; expires on the last permitted cycle.
module renode_ahb_timeout_counter #(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic hclk,
    input  logic hresetn,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CountWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    logic [CountWidth-1:0] count_q;

    always_ff @(posedge hclk) begin
        if (!hresetn || clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CountWidth'(1);
        end
    end

    generate
        if (TimeoutCycles == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            assign expired = enable && (count_q == CountWidth'(TimeoutCycles - 1));
        end
    endgenerate

endmodule

// File: rtl/renode_ahb_subordinate_bridge.sv
// AHB-Lite subordinate front-end: turns each legal single transfer into a held
// backend request and reports OKAY/ERROR back onto the bus.
//
// state     | meaning
// ----------+------------------------------------------------------------
// Idle      | no transfer in flight, zero-wait OKAY
// WriteData | write data phase, capture hwdata/hwstrb
// Request   | req_valid held, waiting on backend or watchdog
// Response  | OKAY completion cycle, next address phase may be accepted
// Error1    | first ERROR cycle, hreadyout low
// Error2    | second ERROR cycle, next address phase may be accepted
module renode_ahb_subordinate_bridge
    import renode_ahb_pkg::*;
#(
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    input  logic                      hsel,
    input  logic [AddressWidth-1:0]   haddr,
    input  logic [1:0]                htrans,
    input  logic                      hwrite,
    input  logic [2:0]                hsize,
    input  logic [2:0]                hburst,
    input  logic [DataWidth-1:0]      hwdata,
    input  logic [DataWidth/8-1:0]    hwstrb,
    input  logic                      hready,
    output logic                      hreadyout,
    output logic                      hresp,
    output logic [DataWidth-1:0]      hrdata,
    output logic                      req_valid,
    output logic                      req_write,
    output logic [AddressWidth-1:0]   req_addr,
    output logic [2:0]                req_size,
    output logic [DataWidth-1:0]      req_wdata,
    output logic [DataWidth/8-1:0]    req_wstrb,
    input  logic                      resp_valid,
    input  logic [DataWidth-1:0]      resp_rdata,
    input  logic                      resp_error
);

    subordinate_state_e state_q, state_d;
    response_t          resp_d;

    logic [AddressWidth-1:0] addr_q;
    logic                    write_q;
    logic [2:0]              size_q;
    logic [DataWidth-1:0]    wdata_q;
    logic [DataWidth/8-1:0]  wstrb_q;
    logic [DataWidth-1:0]    hrdata_q;

    logic accept_window;
    logic accept;
    logic legal;
    logic tmo_expired;

    // Burst type and SEQ/NONSEQ distinction do not change how a beat is served.
    logic unused_inputs;
    assign unused_inputs = ^{hburst, htrans[0]};

    assign accept_window = (state_q == Idle) || (state_q == Response) || (state_q == Error2);
    assign accept        = accept_window && hready && hsel && htrans[1];
    assign legal         = is_transfer_legal(haddr[2:0], hsize, DataWidth);

    renode_ahb_timeout_counter #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout (
        .hclk    (hclk),
        .hresetn (hresetn),
        .enable  (state_q == Request),
        .clear   (state_d != Request),
        .expired (tmo_expired)
    );

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q  <= Idle;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            hrdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= haddr;
                write_q <= hwrite;
                size_q  <= hsize;
            end
            if (state_q == WriteData) begin
                wdata_q <= hwdata;
                wstrb_q <= hwstrb;
            end
            if ((state_q == Request) && resp_valid && !resp_error && !write_q) begin
                hrdata_q <= resp_rdata;
            end
        end
    end

    // A backend response in the same cycle as watchdog expiry takes precedence.
    always_comb begin
        state_d   = state_q;
        hreadyout = 1'b1;
        resp_d    = RespOkay;
        unique case (state_q)
            Idle, Response, Error2: begin
                if (state_q == Error2) begin
                    resp_d = RespError;
                end
                if (accept) begin
                    if (!legal) begin
                        state_d = Error1;
                    end else if (hwrite) begin
                        state_d = WriteData;
                    end else begin
                        state_d = Request;
                    end
                end else begin
                    state_d = Idle;
                end
            end
            WriteData: begin
                hreadyout = 1'b0;
                state_d   = Request;
            end
            Request: begin
                hreadyout = 1'b0;
                if (resp_valid) begin
                    state_d = resp_error ? Error1 : Response;
                end else if (tmo_expired) begin
                    state_d = Error1;
                end
            end
            Error1: begin
                hreadyout = 1'b0;
                resp_d    = RespError;
                state_d   = Error2;
            end
            default: begin
                state_d = Idle;
            end
        endcase
    end

    assign hresp     = resp_d;
    assign hrdata    = hrdata_q;
    assign req_valid = (state_q == Request);
    assign req_write = write_q;
    assign req_addr  = addr_q;
    assign req_size  = size_q;
    assign req_wdata = wdata_q;
    assign req_wstrb = wstrb_q;

endmodule

// File: tb/tb_renode_ahb_subordinate_bridge.sv
// Self-checking bench for renode_ahb_subordinate_bridge (TimeoutCycles = 4).
module tb_renode_ahb_subordinate_bridge;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 4;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [DW-1:0] hwdata;
    logic [3:0]    hwstrb;
    logic          hready;
    logic          hreadyout;
    logic          hresp;
    logic [DW-1:0] hrdata;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_size;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_wstrb;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_error;

    logic hready_ovr_en;
    logic hready_ovr;
    assign hready = hready_ovr_en ? hready_ovr : hreadyout;

    always #5 hclk = ~hclk;

    renode_ahb_subordinate_bridge #(
        .AddressWidth (AW),
        .DataWidth    (DW),
        .TimeoutCycles(TMO)
    ) dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .hsel       (hsel),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsize      (hsize),
        .hburst     (hburst),
        .hwdata     (hwdata),
        .hwstrb     (hwstrb),
        .hready     (hready),
        .hreadyout  (hreadyout),
        .hresp      (hresp),
        .hrdata     (hrdata),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error)
    );

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic        err;
        logic [31:0] rdata;
    } xfer_t;

    typedef struct {
        xfer_t       x;
        int          waits;
        logic        resp;
        int          req_cycles;
        logic [31:0] hrdata;
    } vec_t;

    typedef struct {
        int          waits;
        int          req_cycles;
        logic        resp_final;
        logic        last_wait_hresp;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          unstable;
        logic [31:0] hrdata;
    } obs_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Backend model state
    logic        be_en;
    int          be_lat;
    logic        be_err;
    logic [31:0] be_rdata;
    int          be_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
        if (be_en) begin
            if (req_valid) begin
                resp_valid = (be_cnt == be_lat);
                resp_rdata = resp_valid ? be_rdata : $urandom;
                resp_error = be_err;
                be_cnt++;
            end else begin
                resp_valid = 1'b0;
                be_cnt     = 0;
            end
        end
        #1;
    endtask

    function automatic xfer_t mkx(input logic [31:0] addr, input logic [2:0] size, input logic write,
                                  input logic [31:0] wdata, input logic [3:0] wstrb, input int lat,
                                  input logic err, input logic [31:0] rdata);
        xfer_t x;
        x.addr = addr; x.size = size; x.write = write; x.wdata = wdata; x.wstrb = wstrb;
        x.lat = lat; x.err = err; x.rdata = rdata;
        return x;
    endfunction

    function automatic vec_t mkv(input xfer_t x, input int waits, input logic resp,
                                 input int req_cycles, input logic [31:0] hr);
        vec_t v;
        v.x = x; v.waits = waits; v.resp = resp; v.req_cycles = req_cycles; v.hrdata = hr;
        return v;
    endfunction

    // Transaction-level reference: legality, backend latency vs watchdog, resulting wait states.
    function automatic void model(input xfer_t x, inout logic [31:0] hr, output int waits,
                                  output logic resp, output int reqc);
        bit legal;
        bit served;
        legal = (x.size <= 2) && ((x.addr % (32'd1 << x.size)) == 0);
        if (!legal) begin
            waits = 1; resp = 1'b1; reqc = 0;
            return;
        end
        served = (x.lat < int'(TMO));
        reqc   = served ? x.lat + 1 : int'(TMO);
        resp   = !served || x.err;
        waits  = (x.write ? 1 : 0) + reqc + (resp ? 1 : 0);
        if (served && !x.err && !x.write) hr = x.rdata;
    endfunction

    // Drives one NONSEQ transfer, starting in a cycle where the bridge reports ready.
    task automatic do_xfer(input xfer_t x, output obs_t o);
        o = '{default: 0};
        be_lat = x.lat; be_err = x.err; be_rdata = x.rdata; be_cnt = 0; be_en = 1'b1;
        hsel = 1'b1; htrans = 2'b10; haddr = x.addr; hwrite = x.write; hsize = x.size;
        hburst = 3'($urandom_range(0, 7));
        tick();
        hsel = 1'($urandom_range(0, 1)); htrans = 2'b00; haddr = $urandom;
        hwdata = x.wdata; hwstrb = x.wstrb;
        while (hreadyout == 1'b0 && o.waits < 100) begin
            if (req_valid) begin
                if (o.req_cycles == 0) begin
                    o.addr = req_addr; o.size = req_size; o.write = req_write;
                    o.wdata = req_wdata; o.wstrb = req_wstrb;
                end else if (o.addr !== req_addr || o.size !== req_size || o.write !== req_write ||
                             o.wdata !== req_wdata || o.wstrb !== req_wstrb) begin
                    o.unstable++;
                end
                o.req_cycles++;
            end
            o.last_wait_hresp = hresp;
            o.waits++;
            tick();
            hwdata = $urandom; hwstrb = 4'($urandom);
        end
        o.resp_final = hresp;
        o.hrdata     = hrdata;
    endtask

    task automatic check_xfer(input string tag, input xfer_t x, input obs_t o, input int e_waits,
                              input logic e_resp, input int e_req, input logic [31:0] e_hr);
        check({tag, "_waits"}, 64'(o.waits), 64'(e_waits));
        check({tag, "_hresp"}, 64'(o.resp_final), 64'(e_resp));
        check({tag, "_hresp_wait"}, 64'(o.last_wait_hresp), 64'(e_resp));
        check({tag, "_req_cycles"}, 64'(o.req_cycles), 64'(e_req));
        check({tag, "_hrdata"}, 64'(o.hrdata), 64'(e_hr));
        if (e_req > 0) begin
            check({tag, "_req_addr"}, 64'(o.addr), 64'(x.addr));
            check({tag, "_req_size"}, 64'(o.size), 64'(x.size));
            check({tag, "_req_write"}, 64'(o.write), 64'(x.write));
            check({tag, "_req_stable"}, 64'(o.unstable), 64'd0);
            if (x.write) begin
                check({tag, "_req_wdata"}, 64'(o.wdata), 64'(x.wdata));
                check({tag, "_req_wstrb"}, 64'(o.wstrb), 64'(x.wstrb));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_watchdog: actual running required finished");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[14];
        obs_t        o;
        logic [31:0] exp_hr;
        logic [31:0] hr_before;

        vecs[0]  = mkv(mkx(32'h0,   3'd2, 1'b0, 32'h0,        4'h0, 0,    1'b0, 32'h11111111), 1, 1'b0, 1, 32'h11111111);
        vecs[1]  = mkv(mkx(32'h4,   3'd2, 1'b1, 32'hA5A5A5A5, 4'hF, 0,    1'b0, 32'h99999999), 2, 1'b0, 1, 32'h11111111);
        vecs[2]  = mkv(mkx(32'h8,   3'd2, 1'b0, 32'h0,        4'h0, 0,    1'b0, 32'h22222222), 1, 1'b0, 1, 32'h22222222);
        vecs[3]  = mkv(mkx(32'h100, 3'd2, 1'b0, 32'h0,        4'h0, 0,    1'b0, 32'hDEADBEEF), 1, 1'b0, 1, 32'hDEADBEEF);
        vecs[4]  = mkv(mkx(32'h103, 3'd0, 1'b1, 32'hAB000000, 4'h8, 0,    1'b0, 32'h0),        2, 1'b0, 1, 32'hDEADBEEF);
        vecs[5]  = mkv(mkx(32'h101, 3'd1, 1'b0, 32'h0,        4'h0, 0,    1'b0, 32'h33333333), 1, 1'b1, 0, 32'hDEADBEEF);
        vecs[6]  = mkv(mkx(32'h0,   3'd3, 1'b0, 32'h0,        4'h0, 0,    1'b0, 32'h44444444), 1, 1'b1, 0, 32'hDEADBEEF);
        vecs[7]  = mkv(mkx(32'h200, 3'd2, 1'b0, 32'h0,        4'h0, 1000, 1'b0, 32'h55555555), 5, 1'b1, 4, 32'hDEADBEEF);
        vecs[8]  = mkv(mkx(32'h204, 3'd2, 1'b0, 32'h0,        4'h0, 0,    1'b1, 32'h66666666), 2, 1'b1, 1, 32'hDEADBEEF);
        vecs[9]  = mkv(mkx(32'h208, 3'd2, 1'b0, 32'h0,        4'h0, 3,    1'b0, 32'h12345678), 4, 1'b0, 4, 32'h12345678);
        vecs[10] = mkv(mkx(32'h2,   3'd1, 1'b1, 32'h0000BEEF, 4'h3, 2,    1'b0, 32'h0),        4, 1'b0, 3, 32'h12345678);
        vecs[11] = mkv(mkx(32'h6,   3'd2, 1'b1, 32'h01020304, 4'hF, 0,    1'b0, 32'h0),        1, 1'b1, 0, 32'h12345678);
        vecs[12] = mkv(mkx(32'h10,  3'd1, 1'b0, 32'h0,        4'h0, 1,    1'b0, 32'hCAFEF00D), 2, 1'b0, 2, 32'hCAFEF00D);
        vecs[13] = mkv(mkx(32'h8,   3'd2, 1'b1, 32'h77777777, 4'hF, 1000, 1'b0, 32'h0),        6, 1'b1, 4, 32'hCAFEF00D);

        hresetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
        hburst = 3'd0; hwdata = '0; hwstrb = '0; hready_ovr_en = 1'b0; hready_ovr = 1'b1;
        resp_valid = 1'b0; resp_rdata = '0; resp_error = 1'b0;
        be_en = 1'b0; be_lat = 0; be_err = 1'b0; be_rdata = '0; be_cnt = 0;

        // Reset
        tick(); tick();
        hresetn = 1'b1;
        tick();
        check("rst_hreadyout", 64'(hreadyout), 64'd1);
        check("rst_hresp", 64'(hresp), 64'd0);
        check("rst_hrdata", 64'(hrdata), 64'd0);
        check("rst_req_valid", 64'(req_valid), 64'd0);
        check("rst_req_addr", 64'(req_addr), 64'd0);

        // Directed table, issued back to back (pipelined accepts in RESP/ERR2)
        for (int i = 0; i < 14; i++) begin
            do_xfer(vecs[i].x, o);
            check_xfer($sformatf("vec%0d", i), vecs[i].x, o, vecs[i].waits, vecs[i].resp,
                       vecs[i].req_cycles, vecs[i].hrdata);
        end

        // Late backend response after a timeout must be ignored
        hsel = 1'b0; htrans = 2'b00;
        be_en = 1'b0; resp_valid = 1'b0;
        tick(); tick();
        resp_valid = 1'b1; resp_rdata = 32'h5A5A5A5A; resp_error = 1'b0;
        tick();
        resp_valid = 1'b0;
        check("late_resp_hrdata", 64'(hrdata), 64'hCAFEF00D);
        check("late_resp_req_valid", 64'(req_valid), 64'd0);
        check("late_resp_hreadyout", 64'(hreadyout), 64'd1);
        check("late_resp_hresp", 64'(hresp), 64'd0);

        // Non-transfer address phases: unselected, BUSY, IDLE, bus not ready
        for (int p = 0; p < 4; p++) begin
            hsel = (p != 0); htrans = (p == 1) ? 2'b01 : (p == 2) ? 2'b00 : 2'b10;
            hwrite = 1'b0; hsize = 3'd2; haddr = 32'h40;
            hready_ovr_en = (p == 3); hready_ovr = 1'b0;
            tick();
            hsel = 1'b0; htrans = 2'b00; hready_ovr_en = 1'b0;
            check($sformatf("noxfer%0d_req_valid", p), 64'(req_valid), 64'd0);
            check($sformatf("noxfer%0d_hreadyout", p), 64'(hreadyout), 64'd1);
            check($sformatf("noxfer%0d_hresp", p), 64'(hresp), 64'd0);
        end

        // Reset in the middle of a request
        be_en = 1'b0;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h400; hwrite = 1'b0; hsize = 3'd2;
        tick();
        hsel = 1'b0; htrans = 2'b00;
        check("midrst_req_before", 64'(req_valid), 64'd1);
        hresetn = 1'b0;
        tick();
        check("midrst_req_valid", 64'(req_valid), 64'd0);
        check("midrst_hreadyout", 64'(hreadyout), 64'd1);
        check("midrst_hrdata", 64'(hrdata), 64'd0);
        hresetn = 1'b1;
        resp_valid = 1'b1; resp_rdata = 32'h77777777; resp_error = 1'b0;
        tick();
        resp_valid = 1'b0;
        check("midrst_late_hrdata", 64'(hrdata), 64'd0);
        check("midrst_late_req", 64'(req_valid), 64'd0);

        // Randomized traffic against the transaction-level model
        exp_hr = 32'h0;
        for (int n = 0; n < 150; n++) begin
            xfer_t x;
            int    e_waits;
            int    e_req;
            logic  e_resp;
            int    gap;
            int    lats[7];
            lats = '{0, 0, 1, 2, 3, 4, 6};
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 1) == 0) begin
                    hsel = 1'b0; htrans = 2'b10;
                end else begin
                    hsel = 1'b1; htrans = 2'($urandom_range(0, 1));
                end
                haddr = $urandom; hwrite = 1'($urandom_range(0, 1));
                tick();
                check($sformatf("rnd%0d_gap_req", n), 64'(req_valid), 64'd0);
                check($sformatf("rnd%0d_gap_ready", n), 64'(hreadyout | (hresp << 1)), 64'd1);
            end
            x.addr  = {$urandom_range(0, 255), 3'($urandom_range(0, 7))};
            x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            x.write = 1'($urandom_range(0, 1));
            x.wdata = $urandom;
            x.wstrb = 4'($urandom);
            x.lat   = lats[$urandom_range(0, 6)];
            x.err   = ($urandom_range(0, 7) == 0);
            x.rdata = $urandom;
            hr_before = exp_hr;
            model(x, exp_hr, e_waits, e_resp, e_req);
            do_xfer(x, o);
            check_xfer($sformatf("rnd%0d", n), x, o, e_waits, e_resp, e_req, exp_hr);
            if (x.write) check($sformatf("rnd%0d_hrdata_hold", n), 64'(o.hrdata), 64'(hr_before));
        end

        hsel = 1'b0; htrans = 2'b00;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
